// File: rtl/asteroid_field_if.sv
// Pixel-side and game-side signals of the asteroid field, grouped as one bundle.
// The slave modport is the asteroid_field block; master is whatever drives it.
interface asteroid_field_if #(
  parameter int N_AST   = 4,
  parameter int SPEED_W = 3
);
  logic [9:0]               hcount;
  logic [9:0]               vcount;
  logic                     frame_tick;
  logic                     pause;
  logic                     shield;
  logic [N_AST-1:0]         spawn_en;
  logic [10*N_AST-1:0]      lane_x;
  logic [SPEED_W*N_AST-1:0] speed;
  logic                     pixel_on;
  logic                     expl_on;
  logic [3:0]               score_inc;
  logic [3:0]               hit_inc;
  logic                     update_valid;
  logic [3:0]               active_cnt;

  modport slave (
    input  hcount, vcount, frame_tick, pause, shield, spawn_en, lane_x, speed,
    output pixel_on, expl_on, score_inc, hit_inc, update_valid, active_cnt
  );

  modport master (
    output hcount, vcount, frame_tick, pause, shield, spawn_en, lane_x, speed,
    input  pixel_on, expl_on, score_inc, hit_inc, update_valid, active_cnt
  );
endinterface

// File: rtl/asteroid_field.sv
// N_AST independent falling asteroids: per-channel IDLE/FALL/EXPLODE FSM, diamond
// and explosion-box rendering, and per-frame shield-kill / floor-impact reporting.
module asteroid_field #(
  parameter int N_AST       = 4,
  parameter int TOP_Y       = 35,
  parameter int FLOOR_Y     = 515,
  parameter int HALF_H      = 15,
  parameter int DEF_TOP     = 376,
  parameter int DEF_BOT     = 416,
  parameter int EXPL_FRAMES = 8,
  parameter int SPEED_W     = 3,
  parameter int EXPL_HALF   = 4
) (
  input  logic              clk,
  input  logic              reset,
  asteroid_field_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, FALL, EXPLODE} state_t;

  localparam int TW = (EXPL_FRAMES > 1) ? $clog2(EXPL_FRAMES) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(EXPL_FRAMES - 1);

  localparam logic [10:0] TOP      = 11'(TOP_Y);
  localparam logic [10:0] FLOOR    = 11'(FLOOR_Y);
  localparam logic [10:0] HH       = 11'(HALF_H);
  localparam logic [10:0] H2       = 11'(2 * HALF_H);
  localparam logic [10:0] DTOP     = 11'(DEF_TOP);
  localparam logic [10:0] DBOT     = 11'(DEF_BOT);
  localparam logic [10:0] CLAMP_Y  = 11'(FLOOR_Y - 1 - 2 * HALF_H);
  localparam logic [10:0] FLOOR_EY = 11'(FLOOR_Y - 1 - EXPL_HALF);

  localparam logic signed [11:0] S_H  = 12'(HALF_H);
  localparam logic signed [11:0] S_2H = 12'(2 * HALF_H);
  localparam logic signed [11:0] S_E  = 12'(EXPL_HALF);

  state_t             state_q [N_AST];
  state_t             state_d [N_AST];
  logic [9:0]         x_q     [N_AST];
  logic [9:0]         x_d     [N_AST];
  logic [SPEED_W-1:0] spd_q   [N_AST];
  logic [SPEED_W-1:0] spd_d   [N_AST];
  logic [10:0]        y_q     [N_AST];
  logic [10:0]        y_d     [N_AST];
  logic [10:0]        ey_q    [N_AST];
  logic [10:0]        ey_d    [N_AST];
  logic [TW-1:0]      tmr_q   [N_AST];
  logic [TW-1:0]      tmr_d   [N_AST];

  logic [10:0]        ny      [N_AST];
  logic [10:0]        bot     [N_AST];
  logic signed [11:0] dx      [N_AST];
  logic signed [11:0] dy      [N_AST];
  logic signed [11:0] edy     [N_AST];

  logic [N_AST-1:0]   fall_hit;
  logic [N_AST-1:0]   expl_hit;
  logic [3:0]         kills;
  logic [3:0]         impacts;
  logic [3:0]         busy_cnt;
  logic               tick;

  assign tick = bus.frame_tick & ~bus.pause;

  function automatic logic signed [11:0] abs12(input logic signed [11:0] v);
    return v[11] ? -v : v;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < N_AST; i++) begin
      ny[i]  = y_q[i] + 11'(spd_q[i]);
      bot[i] = ny[i] + H2;
      dx[i]  = {2'b00, bus.hcount} - {2'b00, x_q[i]};
      dy[i]  = {2'b00, bus.vcount} - {1'b0, y_q[i]};
      edy[i] = {2'b00, bus.vcount} - {1'b0, ey_q[i]};
    end
  end

  // Next-state logic for every channel; shield kill outranks floor impact.
  always_comb begin
    kills   = '0;
    impacts = '0;
    for (int unsigned i = 0; i < N_AST; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      spd_d[i]   = spd_q[i];
      y_d[i]     = y_q[i];
      ey_d[i]    = ey_q[i];
      tmr_d[i]   = tmr_q[i];
      if (tick) begin
        unique case (state_q[i])
          IDLE: begin
            if (bus.spawn_en[i]) begin
              state_d[i] = FALL;
              x_d[i]     = bus.lane_x[i*10 +: 10];
              spd_d[i]   = (bus.speed[i*SPEED_W +: SPEED_W] == '0) ? SPEED_W'(1)
                                                                    : bus.speed[i*SPEED_W +: SPEED_W];
              y_d[i]     = TOP;
            end
          end
          FALL: begin
            if (bus.shield && (ny[i] <= DBOT) && (bot[i] >= DTOP)) begin
              state_d[i] = EXPLODE;
              y_d[i]     = ny[i];
              ey_d[i]    = ny[i] + HH;
              tmr_d[i]   = TLOAD;
              if (kills != 4'(N_AST)) kills = kills + 4'd1;
            end else if (bot[i] >= FLOOR) begin
              state_d[i] = EXPLODE;
              y_d[i]     = CLAMP_Y;
              ey_d[i]    = FLOOR_EY;
              tmr_d[i]   = TLOAD;
              if (impacts != 4'(N_AST)) impacts = impacts + 4'd1;
            end else begin
              y_d[i] = ny[i];
            end
          end
          EXPLODE: begin
            if (tmr_q[i] == '0) begin
              state_d[i] = IDLE;
              y_d[i]     = TOP;
            end else begin
              tmr_d[i] = tmr_q[i] - 1'b1;
            end
          end
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  // The column never changes after spawn, so x doubles as the explosion centre column.
  always_comb begin
    fall_hit = '0;
    expl_hit = '0;
    busy_cnt = '0;
    for (int unsigned i = 0; i < N_AST; i++) begin
      fall_hit[i] = (state_q[i] == FALL) && !dy[i][11] && (dy[i] <= S_2H) &&
                    (abs12(dx[i]) <= (S_H - abs12(dy[i] - S_H)));
      expl_hit[i] = (state_q[i] == EXPLODE) && (abs12(dx[i]) <= S_E) &&
                    (abs12(edy[i]) <= S_E);
      if (state_q[i] != IDLE) busy_cnt = busy_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_AST; i++) begin
        state_q[i] <= IDLE;
        x_q[i]     <= '0;
        spd_q[i]   <= '0;
        y_q[i]     <= TOP;
        ey_q[i]    <= '0;
        tmr_q[i]   <= '0;
      end
      bus.pixel_on     <= 1'b0;
      bus.expl_on      <= 1'b0;
      bus.score_inc    <= '0;
      bus.hit_inc      <= '0;
      bus.update_valid <= 1'b0;
      bus.active_cnt   <= '0;
    end else begin
      for (int unsigned i = 0; i < N_AST; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        spd_q[i]   <= spd_d[i];
        y_q[i]     <= y_d[i];
        ey_q[i]    <= ey_d[i];
        tmr_q[i]   <= tmr_d[i];
      end
      bus.pixel_on     <= |fall_hit;
      bus.expl_on      <= |expl_hit;
      bus.score_inc    <= tick ? kills : '0;
      bus.hit_inc      <= tick ? impacts : '0;
      bus.update_valid <= tick;
      bus.active_cnt   <= busy_cnt;
    end
  end
endmodule

// File: tb/tb_asteroid_field.sv
// Directed bench for asteroid_field: spawn/render, floor impact and explosion
// lifetime, shield kills, pause freeze and mid-frame reset.
module tb_asteroid_field;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  asteroid_field_if #(.N_AST(4), .SPEED_W(3)) bus ();

  asteroid_field #(.N_AST(4), .SPEED_W(3)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_tick(output logic uv, output logic [3:0] sc, output logic [3:0] hi);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(posedge clk);
    #1;
    uv = bus.update_valid;
    sc = bus.score_inc;
    hi = bus.hit_inc;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic probe(input string tag, input int h, input int v,
                       input logic p_exp, input logic e_exp);
    @(negedge clk);
    bus.hcount = 10'(h);
    bus.vcount = 10'(v);
    @(posedge clk);
    #1;
    check({tag, "_pix"}, 32'(bus.pixel_on), 32'(p_exp));
    check({tag, "_expl"}, 32'(bus.expl_on), 32'(e_exp));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic       uv;
  logic [3:0] sc;
  logic [3:0] hi;
  int         bad;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.hcount = '0;
    bus.vcount = '0;
    bus.frame_tick = 1'b0;
    bus.pause = 1'b0;
    bus.shield = 1'b0;
    bus.spawn_en = '0;
    bus.lane_x = '0;
    bus.speed = '0;

    // Reset state, no frame_tick after release
    repeat (3) @(negedge clk);
    check("rst_active", 32'(bus.active_cnt), 0);
    check("rst_uv", 32'(bus.update_valid), 0);
    rst_n = 1'b1;
    probe("idle", 320, 50, 1'b0, 1'b0);
    check("idle_active", 32'(bus.active_cnt), 0);
    check("idle_score", 32'(bus.score_inc), 0);
    check("idle_hit", 32'(bus.hit_inc), 0);

    // Spawn ch0 at x=320, speed 2
    bus.spawn_en = 4'b0001;
    bus.lane_x[0 +: 10] = 10'd320;
    bus.speed[0 +: 3] = 3'd2;
    do_tick(uv, sc, hi);
    bus.spawn_en = '0;
    check("spawn_uv", 32'(uv), 1);
    check("spawn_score", 32'(sc), 0);
    check("spawn_hit", 32'(hi), 0);
    probe("ctr_l", 305, 50, 1'b1, 1'b0);
    probe("ctr_r", 335, 50, 1'b1, 1'b0);
    probe("ctr_lo", 304, 50, 1'b0, 1'b0);
    probe("ctr_ro", 336, 50, 1'b0, 1'b0);
    probe("tip_top", 320, 35, 1'b1, 1'b0);
    probe("tip_top_r", 321, 35, 1'b0, 1'b0);
    probe("tip_top_l", 319, 35, 1'b0, 1'b0);
    probe("above", 320, 34, 1'b0, 1'b0);
    probe("tip_bot", 320, 65, 1'b1, 1'b0);
    probe("below", 320, 66, 1'b0, 1'b0);
    check("spawn_active", 32'(bus.active_cnt), 1);

    // Second tick moves by 2: y=37
    do_tick(uv, sc, hi);
    check("mv_uv", 32'(uv), 1);
    probe("mv_old", 320, 36, 1'b0, 1'b0);
    probe("mv_new", 320, 37, 1'b1, 1'b0);

    // Pause: three ticks ignored
    bus.pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_tick(uv, sc, hi);
      check("pause_uv", 32'(uv), 0);
    end
    probe("pause_top", 320, 37, 1'b1, 1'b0);
    probe("pause_ctr", 305, 52, 1'b1, 1'b0);
    probe("pause_abv", 320, 36, 1'b0, 1'b0);
    bus.pause = 1'b0;

    // Floor impact: speed 1, y 35 -> 484 over 449 ticks, impact on the 450th
    pulse_reset();
    bus.shield = 1'b0;
    bus.spawn_en = 4'b0001;
    bus.lane_x[0 +: 10] = 10'd320;
    bus.speed[0 +: 3] = 3'd1;
    do_tick(uv, sc, hi);
    bus.spawn_en = '0;
    bad = 0;
    for (int k = 0; k < 449; k++) begin
      do_tick(uv, sc, hi);
      if (uv !== 1'b1 || hi !== 4'd0 || sc !== 4'd0) bad++;
    end
    check("fall_quiet", 32'(bad), 0);
    probe("floor_bot", 320, 514, 1'b1, 1'b0);
    probe("floor_top", 320, 484, 1'b1, 1'b0);
    do_tick(uv, sc, hi);
    check("impact_uv", 32'(uv), 1);
    check("impact_hit", 32'(hi), 1);
    check("impact_score", 32'(sc), 0);
    probe("boom_ctr", 320, 510, 1'b0, 1'b1);
    probe("boom_edge", 324, 514, 1'b0, 1'b1);
    probe("boom_out", 325, 510, 1'b0, 1'b0);
    probe("boom_sprite", 320, 500, 1'b0, 1'b0);
    bus.spawn_en = 4'b0001;
    for (int k = 1; k < 8; k++) begin
      do_tick(uv, sc, hi);
      probe("boom_live", 320, 510, 1'b0, 1'b1);
    end
    do_tick(uv, sc, hi);
    probe("boom_gone", 320, 510, 1'b0, 1'b0);
    check("boom_active", 32'(bus.active_cnt), 0);
    bus.spawn_en = '0;

    // Shield kill: ch1 x=100, ch2 x=500, speed 4; kill on 78th tick at ny=347
    pulse_reset();
    bus.shield = 1'b1;
    bus.spawn_en = 4'b0110;
    bus.lane_x[10 +: 10] = 10'd100;
    bus.lane_x[20 +: 10] = 10'd500;
    bus.speed[3 +: 3] = 3'd4;
    bus.speed[6 +: 3] = 3'd4;
    do_tick(uv, sc, hi);
    bus.spawn_en = '0;
    bad = 0;
    for (int k = 0; k < 77; k++) begin
      do_tick(uv, sc, hi);
      if (sc !== 4'd0 || hi !== 4'd0) bad++;
    end
    check("band_quiet", 32'(bad), 0);
    do_tick(uv, sc, hi);
    check("kill_uv", 32'(uv), 1);
    check("kill_score", 32'(sc), 2);
    check("kill_hit", 32'(hi), 0);
    probe("kill1_ctr", 100, 362, 1'b0, 1'b1);
    probe("kill1_edge", 104, 366, 1'b0, 1'b1);
    probe("kill1_out", 100, 367, 1'b0, 1'b0);
    probe("kill2_edge", 500, 358, 1'b0, 1'b1);
    probe("kill2_out", 505, 362, 1'b0, 1'b0);
    check("kill_active", 32'(bus.active_cnt), 2);

    // Mid-frame reset with explosions live and ch0 falling
    bus.spawn_en = 4'b0001;
    bus.lane_x[0 +: 10] = 10'd320;
    bus.speed[0 +: 3] = 3'd1;
    do_tick(uv, sc, hi);
    bus.spawn_en = '0;
    probe("pre_rst_fall", 320, 36, 1'b1, 1'b0);
    probe("pre_rst_expl", 100, 362, 1'b0, 1'b1);
    check("pre_rst_active", 32'(bus.active_cnt), 3);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_expl", 32'(bus.expl_on), 0);
    check("rst_pix", 32'(bus.pixel_on), 0);
    check("rst_uv2", 32'(bus.update_valid), 0);
    check("rst_active2", 32'(bus.active_cnt), 0);
    @(negedge clk);
    bus.frame_tick = 1'b0;
    rst_n = 1'b1;
    probe("post_rst_expl", 100, 362, 1'b0, 1'b0);
    probe("post_rst_fall", 320, 36, 1'b0, 1'b0);
    check("post_rst_uv", 32'(bus.update_valid), 0);
    check("post_rst_active", 32'(bus.active_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/asteroid_field.md
Name: asteroid_field

Overview:
- Parametrised successor to the single-asteroid sprite block: manages N_AST independent falling asteroids, each with its own lane, speed and explosion lifetime.
- Renders a diamond asteroid sprite and an explosion box per pixel against the VGA counters.
- Detects shield kills in the defence band and floor impacts, and reports per-frame score and health increments to the scoring/health logic.
- Sits between the VGA timing generator and the colour mux.

Parameters:
N_AST, 4, number of asteroid channels (1..8)
TOP_Y, 35, spawn y of asteroid top edge
FLOOR_Y, 515, floor line; impact when bottom edge >= FLOOR_Y
HALF_H, 15, asteroid half-height; sprite is 2*HALF_H+1 rows
DEF_TOP, 376, defence band top row (inclusive)
DEF_BOT, 416, defence band bottom row (inclusive)
EXPL_FRAMES, 8, explosion lifetime in frames
SPEED_W, 3, width of per-channel speed field (pixels per frame)
EXPL_HALF, 4, explosion box half-size in pixels

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous active-low reset
hcount  in  10  current pixel column
vcount  in  10  current pixel row
frame_tick  in  1  one-cycle pulse per frame, issued during vertical blanking
pause  in  1  1 = freeze motion and explosion timers; rendering continues
shield  in  1  defence system active
spawn_en  in  N_AST  per-channel spawn request, sampled on frame_tick
lane_x  in  10*N_AST  per-channel column centre, latched at spawn
speed  in  SPEED_W*N_AST  per-channel fall speed, latched at spawn; 0 is treated as 1
pixel_on  out  1  registered; current pixel lies inside any falling asteroid
expl_on  out  1  registered; current pixel lies inside any explosion box
score_inc  out  4  shield kills in the last frame update; valid for one cycle
hit_inc  out  4  floor impacts in the last frame update; valid for one cycle
update_valid  out  1  one-cycle strobe qualifying score_inc and hit_inc
active_cnt  out  4  number of channels not in IDLE

Behaviour:
Reset:
- All channels enter IDLE with y = TOP_Y.
- All outputs are 0.
- Reset asserted mid-frame aborts falls and explosions immediately, with no increments reported.

Per-channel FSM (IDLE, FALL, EXPLODE). All transitions happen only on cycles where frame_tick=1 and pause=0.
- IDLE: if spawn_en[i], latch x = lane_x[i], spd = max(speed[i],1), set y = TOP_Y, go to FALL.
- FALL: compute ny = y + spd, with 11-bit arithmetic and no wrap.
  - Shield kill: shield=1 and rows [ny, ny+2*HALF_H] overlap [DEF_TOP, DEF_BOT]. Go to EXPLODE, count toward score_inc, latch ex = x, ey = ny + HALF_H.
  - Floor impact: otherwise, if ny + 2*HALF_H >= FLOOR_Y, clamp y so the bottom edge sits at FLOOR_Y-1. Go to EXPLODE, count toward hit_inc, latch ey = FLOOR_Y-1-EXPL_HALF.
  - Otherwise y = ny.
  - Shield kill has priority over floor impact in the same frame.
- EXPLODE: timer loaded to EXPL_FRAMES-1 on entry. On each qualifying tick, decrement; at 0 go to IDLE. An explosion therefore lasts exactly EXPL_FRAMES frame ticks. spawn_en is ignored until the channel is back in IDLE.
- pause=1: frame_tick is ignored entirely, so no spawns, no motion, no timer change and no update_valid.

Increments:
- score_inc, hit_inc and update_valid are asserted in the cycle after a qualifying frame_tick.
- Values are saturating counts over all channels, at most N_AST.
- update_valid is 1 even when both counts are 0.

Rendering (1-cycle latency from hcount/vcount to pixel_on/expl_on):
- Channel i in FALL draws a pixel when dy = vcount - y is in 0..2*HALF_H and |hcount - x| <= HALF_H - |dy - HALF_H|. The top and bottom tip rows are therefore 1 pixel wide.
- Channel i in EXPLODE draws when |hcount - ex| <= EXPL_HALF and |vcount - ey| <= EXPL_HALF.
- Each output is the OR over all channels.
- Column arithmetic is signed 11-bit so sprites near x=0 clip rather than wrap.

active_cnt is a registered population count of non-IDLE channels.

Test Plan:
1. Reset low, then high with frame_tick absent -> pixel_on=0, active_cnt=0, all increments 0.
2. N_AST=4, spawn_en=0001, lane_x[0]=320, speed=2, one tick -> ch0 y=35. At vcount=50 (centre row) pixels 305..335 are on; at vcount=35 only column 320 is on; active_cnt=1.
3. shield=0, speed=1, run ticks -> ch0 reaches bottom edge 514, then explodes. That tick yields update_valid=1, hit_inc=1, score_inc=0. expl_on appears for exactly 8 ticks, then active_cnt=0.
4. shield=1, two channels with speed 4, both entering the band on the same tick -> score_inc=2, hit_inc=0. Two explosion boxes are centred at their kill rows.
5. pause=1 with 3 frame_ticks mid-fall -> y unchanged, no update_valid. Sprite is still rendered at the same rows.
6. Assert reset during EXPLODE of ch0 and FALL of ch1 -> next cycle all channels IDLE, expl_on=0, pixel_on=0, no increment strobe.
